// File: rtl/wb_port_arbiter_if.sv
// Writeback request/port bundle between execution units and the regfile
// write-port arbiter. The arbiter uses the slave view; the requester side
// (and the regfile observer) uses the master view.
interface wb_port_arbiter_if #(
  parameter int NREQ = 6
);
  logic [NREQ-1:0]    req_valid;
  logic [6*NREQ-1:0]  req_waddr;
  logic [64*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic               we0, we1, we2, we3;
  logic [5:0]         waddr0, waddr1, waddr2, waddr3;
  logic [63:0]        wdata0, wdata1, wdata2, wdata3;
  logic [15:0]        conflict_cnt;

  modport master (
    output req_valid, req_waddr, req_wdata,
    input  req_ready, we0, we1, we2, we3, waddr0, waddr1, waddr2, waddr3,
           wdata0, wdata1, wdata2, wdata3, conflict_cnt
  );

  modport slave (
    input  req_valid, req_waddr, req_wdata,
    output req_ready, we0, we1, we2, we3, waddr0, waddr1, waddr2, waddr3,
           wdata0, wdata1, wdata2, wdata3, conflict_cnt
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Writeback scheduler: packs up to 4 completion writes per cycle onto the
// regfile write ports, round-robin fair. HILO (addr 32) may only use port 0,
// $zero writes are swallowed, and two grants to one GPR never share a cycle.
module wb_port_arbiter #(
  parameter int NREQ = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  wb_port_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]             rr_ptr, rr_nxt, last_k, last_req;
  logic [NREQ-1:0][PW-1:0]   order;
  logic [NREQ-1:0][5:0]      addr;
  logic [NREQ-1:0][63:0]     data;
  logic [NREQ-1:0]           ready;
  logic [3:0]                g_we, we_q;
  logic [3:0][5:0]           g_addr, waddr_q;
  logic [3:0][63:0]          g_data, wdata_q;
  logic [2:0]                nport;
  logic [31:0]               used;
  logic                      hilo, any_grant, conflict;
  logic [15:0]               cnt_q;

  assign addr = bus.req_waddr;
  assign data = bus.req_wdata;

  // Scan order: order[k] = (rr_ptr + k) mod NREQ; one conditional subtract
  // suffices since both operands are below NREQ.
  for (genvar k = 0; k < NREQ; k++) begin : g_ord
    logic [PW:0] s;
    assign s = {1'b0, rr_ptr} + (PW+1)'(k);
    assign order[k] = (s >= (PW+1)'(NREQ)) ? PW'(s - (PW+1)'(NREQ)) : s[PW-1:0];
  end

  // Allocation: $zero accept, then one HILO onto port 0, then GPRs fill the
  // next free ports in scan order, skipping addresses already granted.
  always_comb begin
    ready     = '0;
    g_we      = '0;
    g_addr    = '0;
    g_data    = '0;
    used      = '0;
    nport     = '0;
    hilo      = 1'b0;
    last_k    = '0;
    any_grant = 1'b0;
    if (!flush) begin
      for (int k = 0; k < NREQ; k++) begin
        if (bus.req_valid[order[k]] && addr[order[k]] == 6'd0)
          ready[order[k]] = 1'b1;
      end
      for (int k = 0; k < NREQ; k++) begin
        if (!hilo && bus.req_valid[order[k]] && addr[order[k]] == 6'd32) begin
          hilo             = 1'b1;
          ready[order[k]]  = 1'b1;
          g_we[0]          = 1'b1;
          g_addr[0]        = 6'd32;
          g_data[0]        = data[order[k]];
          nport            = 3'd1;
          any_grant        = 1'b1;
          last_k           = PW'(k);
        end
      end
      for (int k = 0; k < NREQ; k++) begin
        if (bus.req_valid[order[k]] && addr[order[k]] != 6'd0 && !addr[order[k]][5] &&
            nport != 3'd4 && !used[addr[order[k]][4:0]]) begin
          ready[order[k]]          = 1'b1;
          used[addr[order[k]][4:0]] = 1'b1;
          g_we[nport[1:0]]         = 1'b1;
          g_addr[nport[1:0]]       = addr[order[k]];
          g_data[nport[1:0]]       = {32'h0, data[order[k]][31:0]};
          nport                    = nport + 3'd1;
          any_grant                = 1'b1;
          if (PW'(k) > last_k) last_k = PW'(k);
        end
      end
    end
  end

  // Pointer moves just past the last requester granted in scan order.
  assign last_req = order[last_k];
  assign rr_nxt   = (last_req == PW'(NREQ - 1)) ? '0 : last_req + 1'b1;

  // A cycle counts as a conflict when any legal valid request is left waiting.
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_valid[i] && addr[i] <= 6'd32 && !ready[i]) conflict = 1'b1;
    end
  end

  // Round-robin pointer and saturating conflict counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (any_grant) rr_ptr <= rr_nxt;
      if (conflict && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
  end

  // Registered write ports; grants are already zero during flush.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      we_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q    <= g_we;
      waddr_q <= g_addr;
      wdata_q <= g_data;
    end
  end

  assign bus.req_ready    = ready;
  assign bus.conflict_cnt = cnt_q;
  assign bus.we0    = we_q[0];
  assign bus.we1    = we_q[1];
  assign bus.we2    = we_q[2];
  assign bus.we3    = we_q[3];
  assign bus.waddr0 = waddr_q[0];
  assign bus.waddr1 = waddr_q[1];
  assign bus.waddr2 = waddr_q[2];
  assign bus.waddr3 = waddr_q[3];
  assign bus.wdata0 = wdata_q[0];
  assign bus.wdata1 = wdata_q[1];
  assign bus.wdata2 = wdata_q[2];
  assign bus.wdata3 = wdata_q[3];
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed scoreboard bench for wb_port_arbiter: each cycle drives requests,
// checks the combinational accepts, queues the expected port contents and
// compares them once the registered outputs appear.
module tb_wb_port_arbiter;
  localparam int NREQ = 6;

  typedef struct packed {
    logic [3:0]       we;
    logic [3:0][5:0]  a;
    logic [3:0][63:0] d;
  } wr_t;
  localparam wr_t Z = '0;

  logic clk = 1'b0;
  logic resetn, flush;
  int   tests = 0, fails = 0;
  wr_t  q[$];

  wb_port_arbiter_if #(.NREQ(NREQ)) bus ();
  wb_port_arbiter #(.NREQ(NREQ)) dut (.clk(clk), .resetn(resetn), .flush(flush), .bus(bus));

  always #5 clk = ~clk;

  logic [3:0]       owe;
  logic [3:0][5:0]  oa;
  logic [3:0][63:0] od;
  assign owe = {bus.we3, bus.we2, bus.we1, bus.we0};
  assign oa  = {bus.waddr3, bus.waddr2, bus.waddr1, bus.waddr0};
  assign od  = {bus.wdata3, bus.wdata2, bus.wdata1, bus.wdata0};

  // Requesters must never present an address above HILO.
  always @(posedge clk) begin
    if (resetn) begin
      for (int i = 0; i < NREQ; i++)
        assert (!(bus.req_valid[i] && bus.req_waddr[6*i +: 6] > 6'd32))
          else $error("illegal waddr from requester %0d", i);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic wr_t put(input wr_t e, input int p, input logic [5:0] a, input logic [63:0] d);
    wr_t r = e;
    r.we[p] = 1'b1;
    r.a[p]  = a;
    r.d[p]  = d;
    return r;
  endfunction

  task automatic idle();
    bus.req_valid = '0;
    bus.req_waddr = '0;
    bus.req_wdata = '0;
  endtask

  task automatic req(input int i, input logic [5:0] a, input logic [63:0] d);
    bus.req_valid[i]          = 1'b1;
    bus.req_waddr[6*i +: 6]   = a;
    bus.req_wdata[64*i +: 64] = d;
  endtask

  task automatic drop(input int i);
    bus.req_valid[i] = 1'b0;
  endtask

  // Called right after a negedge with inputs applied.
  task automatic step(input logic [NREQ-1:0] exp_rdy, input wr_t e);
    wr_t x;
    #1;
    chk("ready", bus.req_ready, exp_rdy);
    q.push_back(e);
    @(posedge clk);
    #1;
    x = q.pop_front();
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("we%0d", p), owe[p], x.we[p]);
      chk($sformatf("waddr%0d", p), oa[p], x.a[p]);
      chk($sformatf("wdata%0d", p), od[p], x.d[p]);
    end
    @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0;
    flush  = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    chk("rst_we", owe, 4'h0);
    chk("rst_waddr", oa, 24'h0);
    chk("rst_cnt", bus.conflict_cnt, 16'h0);
    chk("rst_rr", dut.rr_ptr, 0);
    resetn = 1'b1;
    @(negedge clk);

    // single GPR write, upper half of data dropped
    req(0, 6'd5, 64'hAAAA_BBBB_1234_5678);
    step(6'b000001, put(Z, 0, 6'd5, 64'h0000_0000_1234_5678));
    chk("t1_cnt", bus.conflict_cnt, 16'd0);
    chk("t1_rr", dut.rr_ptr, 1);

    // last requester wraps pointer to 0
    idle(); req(5, 6'd10, 64'h5);
    step(6'b100000, put(Z, 0, 6'd10, 64'h5));
    chk("wrap_rr", dut.rr_ptr, 0);

    // six GPR requests: four now, two next cycle
    idle();
    for (int i = 0; i < NREQ; i++) req(i, 6'(i + 1), 64'h100 + 64'(i));
    step(6'b001111, put(put(put(put(Z, 0, 6'd1, 64'h100), 1, 6'd2, 64'h101),
                                   2, 6'd3, 64'h102), 3, 6'd4, 64'h103));
    chk("t2_rr", dut.rr_ptr, 4);
    chk("t2_cnt", bus.conflict_cnt, 16'd1);
    for (int i = 0; i < 4; i++) drop(i);
    step(6'b110000, put(put(Z, 0, 6'd5, 64'h104), 1, 6'd6, 64'h105));
    chk("t2b_rr", dut.rr_ptr, 0);
    chk("t2b_cnt", bus.conflict_cnt, 16'd1);

    // HILO takes port 0 with full data, GPR moves to port 1
    idle(); req(0, 6'd7, 64'hFFFF_FFFF_0000_0007); req(1, 6'd32, 64'h1111_2222_3333_4444);
    step(6'b000011, put(put(Z, 0, 6'd32, 64'h1111_2222_3333_4444), 1, 6'd7, 64'h7));
    chk("t3_rr", dut.rr_ptr, 2);
    idle(); req(5, 6'd11, 64'hB);
    step(6'b100000, put(Z, 0, 6'd11, 64'hB));
    chk("t3b_rr", dut.rr_ptr, 0);

    // same GPR from two requesters: serialised, later data lands later
    idle(); req(2, 6'd9, 64'hDEAD_0000_0000_0002); req(3, 6'd9, 64'hBEEF_0000_0000_0003);
    step(6'b000100, put(Z, 0, 6'd9, 64'h2));
    chk("t4_cnt", bus.conflict_cnt, 16'd2);
    drop(2);
    step(6'b001000, put(Z, 0, 6'd9, 64'h3));
    chk("t4_rr", dut.rr_ptr, 4);

    // $zero write accepted with no port and no pointer move
    idle(); req(0, 6'd0, 64'h99);
    step(6'b000001, Z);
    chk("t5_rr", dut.rr_ptr, 4);
    chk("t5_cnt", bus.conflict_cnt, 16'd2);

    // flush right after a grant clears ports, holds rr_ptr, counts conflict
    idle(); req(4, 6'd12, 64'hC);
    step(6'b010000, put(Z, 0, 6'd12, 64'hC));
    idle(); flush = 1'b1;
    req(0, 6'd1, 64'h1); req(1, 6'd2, 64'h2); req(2, 6'd3, 64'h3);
    step(6'b000000, Z);
    flush = 1'b0;
    chk("fl_cnt", bus.conflict_cnt, 16'd3);
    chk("fl_rr", dut.rr_ptr, 5);

    // two HILOs plus four GPRs from rr_ptr=5: one HILO, ports fill, rest wait
    idle();
    req(0, 6'd32, 64'hA0A0_A0A0_B0B0_B0B0); req(1, 6'd32, 64'h1);
    req(2, 6'd20, 64'hFFFF_FFFF_2222_2222); req(3, 6'd21, 64'h3333);
    req(4, 6'd22, 64'h4444); req(5, 6'd23, 64'h5555);
    step(6'b101101, put(put(put(put(Z, 0, 6'd32, 64'hA0A0_A0A0_B0B0_B0B0),
                                   1, 6'd23, 64'h5555), 2, 6'd20, 64'h2222_2222),
                        3, 6'd21, 64'h3333));
    chk("hl_rr", dut.rr_ptr, 4);
    chk("hl_cnt", bus.conflict_cnt, 16'd4);

    // async reset while we1 is high
    idle(); req(0, 6'd13, 64'h13); req(1, 6'd14, 64'h14);
    step(6'b000011, put(put(Z, 0, 6'd13, 64'h13), 1, 6'd14, 64'h14));
    idle();
    #2 resetn = 1'b0;
    #1;
    chk("ar_we", owe, 4'h0);
    chk("ar_rr", dut.rr_ptr, 0);
    chk("ar_cnt", bus.conflict_cnt, 16'd0);
    #1 resetn = 1'b1;
    @(negedge clk);
    step(6'b000000, Z);
    chk("ar_q", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
